wshb_arbiter_rr: RTL and testbench

- Parametrised N-master to 1-slave Wishbone B4 arbiter, fronting the SDRAM controller.
- Round-robin fairness replaces the fixed two-master token.
- An optional transfer quantum preempts a master that holds the bus while others wait.
- Terminations (ack/err/rty) go only to the granted master.

---
 rtl/wshb_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/wshb_arbiter_rr.sv | 154 +++++++++++++++
 tb/tb_wshb_arbiter_rr.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_pkg.sv
// Shared Wishbone B4 definitions for the bus fabric in front of the SDRAM controller.
package wshb_pkg;

    // Cycle type identifiers (CTI_O) used to spot burst boundaries.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef logic [2:0] cti_t;
    typedef logic [1:0] bte_t;

    // Arbiter ownership state: IDLE = no owner (dead cycle), BUSY = bus granted.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after last_idx_i, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_idx_i,
    output logic          valid_o,
    output logic [IW-1:0] winner_o
);

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after last_idx_i is the final (winning) assignment.
    always_comb begin
        int idx;
        idx      = 0;
        valid_o  = 1'b0;
        winner_o = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_idx_i) + k) % N;
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/wshb_arbiter_rr.sv
// N-master to 1-slave Wishbone B4 round-robin arbiter with optional
// quantum-based preemption at burst boundaries.
//
// Handshake: a master owns a transfer while cyc&stb are high; the transfer
// completes on the cycle the slave raises ack, err or rty with stb high, and
// that termination is routed only to the master currently granted. A master
// that is not granted simply sees no termination and stays stalled.
module wshb_arbiter_rr
    import wshb_pkg::*;
#(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int QUANTUM = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        s_cyc,
    input  logic [N-1:0]        s_stb,
    input  logic [N-1:0]        s_we,
    input  logic [N*AW-1:0]     s_adr,
    input  logic [N*DW-1:0]     s_dat_ms,
    input  logic [N*(DW/8)-1:0] s_sel,
    input  logic [N*3-1:0]      s_cti,
    input  logic [N*2-1:0]      s_bte,
    output logic [N-1:0]        s_ack,
    output logic [N-1:0]        s_err,
    output logic [N-1:0]        s_rty,
    output logic [DW-1:0]       s_dat_sm,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [AW-1:0]       m_adr,
    output logic [DW-1:0]       m_dat_ms,
    output logic [DW/8-1:0]     m_sel,
    output logic [2:0]          m_cti,
    output logic [1:0]          m_bte,
    input  logic                m_ack,
    input  logic                m_err,
    input  logic                m_rty,
    input  logic [DW-1:0]       m_dat_sm,
    output logic [N-1:0]        gnt
);

    localparam int IW     = (N > 1) ? $clog2(N) : 1;
    localparam int CW_RAW = $clog2(QUANTUM + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int SW     = DW / 8;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] last_idx_q, last_idx_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;

    logic          busy;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  gnt_oh;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    cti_t          cti_g;
    logic          term;
    logic          at_boundary;
    logic          others_req;
    logic          quantum_hit;
    logic          preempt;
    logic          release_bus;

    rr_pick #(.N(N)) u_pick (
        .req_i      (s_cyc),
        .last_idx_i (last_idx_q),
        .valid_o    (pick_valid),
        .winner_o   (pick_idx)
    );

    assign busy    = (state_q == ARB_BUSY);
    // While idle the slave-side buses follow master 0; cyc/stb/we are forced low.
    assign sel_idx = busy ? gnt_idx_q : '0;

    // One-hot grant, all zero during the dead cycle.
    always_comb begin
        gnt_oh = '0;
        if (busy) gnt_oh[gnt_idx_q] = 1'b1;
    end

    // Master-to-slave multiplexer and termination routing.
    always_comb begin
        m_cyc    = busy & s_cyc[sel_idx];
        m_stb    = busy & s_stb[sel_idx];
        m_we     = busy & s_we[sel_idx];
        m_adr    = s_adr[int'(sel_idx)*AW +: AW];
        m_dat_ms = s_dat_ms[int'(sel_idx)*DW +: DW];
        m_sel    = s_sel[int'(sel_idx)*SW +: SW];
        m_cti    = s_cti[int'(sel_idx)*3 +: 3];
        m_bte    = s_bte[int'(sel_idx)*2 +: 2];
        s_ack    = m_ack ? gnt_oh : '0;
        s_err    = m_err ? gnt_oh : '0;
        s_rty    = m_rty ? gnt_oh : '0;
        s_dat_sm = m_dat_sm;
        gnt      = gnt_oh;
    end

    // Release decisions: owner drops cyc, or quantum spent at a burst boundary
    // while someone else waits. Never taken mid incrementing burst.
    always_comb begin
        cti_g       = s_cti[int'(gnt_idx_q)*3 +: 3];
        term        = busy & m_stb & (m_ack | m_err | m_rty);
        at_boundary = (cti_g == CTI_CLASSIC) || (cti_g == CTI_EOB);
        others_req  = |(s_cyc & ~gnt_oh);
        quantum_hit = (QUANTUM > 0) && ((int'(xfer_cnt_q) + 1) >= QUANTUM);
        preempt     = term & quantum_hit & at_boundary & others_req;
        release_bus = ~s_cyc[gnt_idx_q] | preempt;
    end

    // Next-state logic: grant on IDLE, count terminations and release on BUSY.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d    = ARB_BUSY;
                    gnt_idx_d  = pick_idx;
                    xfer_cnt_d = '0;
                end
            end
            ARB_BUSY: begin
                if (term && (xfer_cnt_q != '1)) xfer_cnt_d = xfer_cnt_q + 1'b1;
                if (release_bus) begin
                    state_d    = ARB_IDLE;
                    last_idx_d = gnt_idx_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset leaves master 0 first in the rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IW'(N - 1);
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Self-checking bench for wshb_arbiter_rr: a 3-master instance with QUANTUM=4
// and a 1-master instance with QUANTUM=2, each behind a simple acking slave.
module tb_wshb_arbiter_rr;

    localparam int W = 41;  // {gnt, we, cti, sel, adr, dat_ms}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 3-master instance ----------------
    logic [2:0]  s_cyc, s_stb, s_we, s_ack, s_err, s_rty, gnt;
    logic [47:0] s_adr, s_dat_ms;
    logic [5:0]  s_sel, s_bte;
    logic [8:0]  s_cti;
    logic [15:0] s_dat_sm, m_adr, m_dat_ms, m_dat_sm;
    logic        m_cyc, m_stb, m_we, m_ack, m_err, m_rty;
    logic [1:0]  m_sel, m_bte;
    logic [2:0]  m_cti;

    wshb_arbiter_rr #(.N(3), .AW(16), .DW(16), .QUANTUM(4)) dut_a (
        .clk(clk), .rst(rst),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
        .gnt(gnt)
    );

    // Slave A: answers one cycle after it sees cyc&stb, ack or err by mode.
    logic        err_mode = 1'b0;
    logic        rsp_q;
    logic [15:0] rdat_q;
    always @(posedge clk) begin
        if (rst) rsp_q <= 1'b0;
        else     rsp_q <= m_cyc && m_stb && !rsp_q;
        rdat_q <= m_adr ^ 16'hC3C3;
    end
    assign m_ack    = rsp_q & ~err_mode;
    assign m_err    = rsp_q & err_mode;
    assign m_rty    = 1'b0;
    assign m_dat_sm = rdat_q;

    // ---------------- 1-master instance ----------------
    logic        b_s_cyc, b_s_stb, b_s_we, b_s_ack, b_s_err, b_s_rty, b_gnt;
    logic [15:0] b_s_adr, b_s_dat_ms, b_s_dat_sm, b_m_adr, b_m_dat_ms, b_m_dat_sm;
    logic [1:0]  b_s_sel, b_s_bte, b_m_sel, b_m_bte;
    logic [2:0]  b_s_cti, b_m_cti;
    logic        b_m_cyc, b_m_stb, b_m_we, b_m_ack, b_m_err, b_m_rty;

    wshb_arbiter_rr #(.N(1), .AW(16), .DW(16), .QUANTUM(2)) dut_b (
        .clk(clk), .rst(rst),
        .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
        .s_dat_ms(b_s_dat_ms), .s_sel(b_s_sel), .s_cti(b_s_cti), .s_bte(b_s_bte),
        .s_ack(b_s_ack), .s_err(b_s_err), .s_rty(b_s_rty), .s_dat_sm(b_s_dat_sm),
        .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_adr(b_m_adr),
        .m_dat_ms(b_m_dat_ms), .m_sel(b_m_sel), .m_cti(b_m_cti), .m_bte(b_m_bte),
        .m_ack(b_m_ack), .m_err(b_m_err), .m_rty(b_m_rty), .m_dat_sm(b_m_dat_sm),
        .gnt(b_gnt)
    );

    logic b_rsp_q;
    always @(posedge clk) begin
        if (rst) b_rsp_q <= 1'b0;
        else     b_rsp_q <= b_m_cyc && b_m_stb && !b_rsp_q;
    end
    assign b_m_ack    = b_rsp_q;
    assign b_m_err    = 1'b0;
    assign b_m_rty    = 1'b0;
    assign b_m_dat_sm = 16'h0BAD;

    // ---------------- scoreboard and bookkeeping ----------------
    logic [W-1:0] exp_q[$];
    logic [2:0]   tr_gnt[$];
    logic         tr_cyc[$];
    logic [2:0]   cv[$];
    int           cl[$];
    int           ack_cnt[3];
    int           rem[3], beat[3], total[3];
    bit           bmode[3];
    int           n_chk = 0;
    int           n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] cti_of(input bit burst, input int k, input int tot);
        if (!burst)        return 3'b000;
        if (k == tot - 1)  return 3'b111;
        return 3'b010;
    endfunction

    function automatic logic [15:0] adr_of(input int m, input int k);
        return 16'(32'h1000 * (m + 1) + k);
    endfunction

    function automatic logic [W-1:0] exp_word(input int m, input int k, input int tot, input bit burst);
        logic [15:0] a;
        a = adr_of(m, k);
        return {3'(1 << m), 1'(m == 1), cti_of(burst, k, tot), 2'(m + 1), a, a ^ 16'h5A5A};
    endfunction

    task automatic push_exp(input int m, input int first, input int n, input int tot, input bit burst);
        for (int k = first; k < first + n; k++) exp_q.push_back(exp_word(m, k, tot, burst));
    endtask

    task automatic drive_beat(input int m);
        logic [15:0] a;
        a = adr_of(m, beat[m]);
        s_adr[m*16 +: 16]    = a;
        s_dat_ms[m*16 +: 16] = a ^ 16'h5A5A;
        s_cti[m*3 +: 3]      = cti_of(bmode[m], beat[m], total[m]);
        s_sel[m*2 +: 2]      = 2'(m + 1);
        s_bte[m*2 +: 2]      = 2'(m);
        s_we[m]              = (m == 1);
    endtask

    task automatic start_master(input int m, input int n, input bit burst);
        beat[m] = 0; rem[m] = n; total[m] = n; bmode[m] = burst;
        s_cyc[m] = 1'b1; s_stb[m] = 1'b1;
        drive_beat(m);
    endtask

    task automatic clear_trace();
        tr_gnt.delete(); tr_cyc.delete();
        for (int m = 0; m < 3; m++) ack_cnt[m] = 0;
    endtask

    // Run-length compress the grant trace into cv (values) / cl (lengths).
    task automatic compress_trace();
        cv.delete(); cl.delete();
        foreach (tr_gnt[i]) begin
            if (cv.size() > 0 && cv[cv.size()-1] == tr_gnt[i]) cl[cl.size()-1]++;
            else begin cv.push_back(tr_gnt[i]); cl.push_back(1); end
        end
    endtask

    // Sample at negedge, check terminations against the scoreboard, then
    // advance each master after the following rising edge.
    task automatic run(input int budget, input bit need_done);
        int cyc;
        logic [2:0] done_m;
        logic [W-1:0] e;
        logic [2:0] eg;
        cyc = 0;
        while ((rem[0] + rem[1] + rem[2]) > 0 && cyc < budget) begin
            @(negedge clk);
            tr_gnt.push_back(gnt);
            tr_cyc.push_back(m_cyc);
            for (int m = 0; m < 3; m++) ack_cnt[m] += int'(s_ack[m]);
            if (m_cyc && m_stb && (m_ack || m_err || m_rty)) begin
                e  = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                eg = e[W-1 -: 3];
                check_val("xfer", 64'({gnt, m_we, m_cti, m_sel, m_adr, m_dat_ms}), 64'(e));
                check_val("s_ack_route", 64'(s_ack), 64'(m_ack ? eg : 3'b000));
                check_val("s_err_route", 64'(s_err), 64'(m_err ? eg : 3'b000));
                check_val("s_rty_route", 64'(s_rty), 64'(0));
                check_val("dat_bcast", 64'(s_dat_sm), 64'(m_dat_sm));
            end
            done_m = s_ack | s_err | s_rty;
            @(posedge clk); #1;
            for (int m = 0; m < 3; m++) begin
                if (done_m[m] && rem[m] > 0) begin
                    rem[m]--; beat[m]++;
                    if (rem[m] == 0) begin
                        s_cyc[m] = 1'b0; s_stb[m] = 1'b0; s_cti[m*3 +: 3] = 3'b000;
                    end else drive_beat(m);
                end
            end
            cyc++;
        end
        if (need_done) check_val("run_done", 64'(rem[0] + rem[1] + rem[2]), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; err_mode = 1'b0;
        s_cyc = '0; s_stb = '0; s_we = '0; s_cti = '0;
        b_s_cyc = 1'b0; b_s_stb = 1'b0;
        for (int m = 0; m < 3; m++) rem[m] = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_gnt", 64'(gnt), 64'(0));
        check_val("rst_m_cyc", 64'(m_cyc), 64'(0));
        check_val("rst_s_ack", 64'(s_ack), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        clear_trace();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g1, g2;
        logic [W-1:0] e;
        logic [2:0] t2_seq[6];
        int nb;
        logic b_acked;
        t2_seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        s_cyc = '0; s_stb = '0; s_we = '0; s_adr = '0; s_dat_ms = '0;
        s_sel = '0; s_cti = '0; s_bte = '0;
        b_s_cyc = 1'b0; b_s_stb = 1'b0; b_s_we = 1'b0; b_s_adr = '0; b_s_dat_ms = '0;
        b_s_sel = 2'b11; b_s_cti = 3'b000; b_s_bte = 2'b00;

        // Master 0 alone, four classic transfers.
        do_reset();
        start_master(0, 4, 1'b0);
        push_exp(0, 0, 4, 4, 1'b0);
        run(60, 1'b1);
        @(negedge clk); g1 = gnt;
        @(negedge clk); g2 = gnt;
        check_val("t1_cyc_latency0", 64'(tr_cyc[0]), 64'(0));
        check_val("t1_cyc_latency1", 64'(tr_cyc[1]), 64'(1));
        check_val("t1_ack0_pulses", 64'(ack_cnt[0]), 64'(4));
        check_val("t1_ack1_pulses", 64'(ack_cnt[1]), 64'(0));
        check_val("t1_gnt_hold", 64'(g1), 64'(3'b001));
        check_val("t1_gnt_release", 64'(g2), 64'(3'b000));
        check_val("t1_sb_drained", 64'(exp_q.size()), 64'(0));

        // Three masters request together: order 0,1,2 with one idle cycle between.
        do_reset();
        for (int m = 0; m < 3; m++) start_master(m, 1, 1'b0);
        for (int m = 0; m < 3; m++) push_exp(m, 0, 1, 1, 1'b0);
        run(60, 1'b1);
        compress_trace();
        for (int i = 0; i < 6; i++)
            check_val("t2_gnt_seq", (i < cv.size()) ? 64'(cv[i]) : 64'hDEAD, 64'(t2_seq[i]));
        check_val("t2_idle_gap1", (cl.size() > 2) ? 64'(cl[2]) : 64'hDEAD, 64'(1));
        check_val("t2_idle_gap2", (cl.size() > 4) ? 64'(cl[4]) : 64'hDEAD, 64'(1));
        check_val("t2_sb_drained", 64'(exp_q.size()), 64'(0));

        // 8-beat INCR burst from master 0 is not preempted by master 1.
        do_reset();
        start_master(0, 8, 1'b1);
        start_master(1, 1, 1'b0);
        push_exp(0, 0, 8, 8, 1'b1);
        push_exp(1, 0, 1, 1, 1'b0);
        run(100, 1'b1);
        check_val("t3a_sb_drained", 64'(exp_q.size()), 64'(0));

        // Six classic transfers from master 0: preempted after the 4th ack.
        do_reset();
        start_master(0, 6, 1'b0);
        start_master(1, 1, 1'b0);
        push_exp(0, 0, 4, 6, 1'b0);
        push_exp(1, 0, 1, 1, 1'b0);
        push_exp(0, 4, 2, 6, 1'b0);
        run(100, 1'b1);
        check_val("t3b_sb_drained", 64'(exp_q.size()), 64'(0));

        // Error termination for master 1 goes only to master 1.
        do_reset();
        err_mode = 1'b1;
        start_master(1, 1, 1'b0);
        push_exp(1, 0, 1, 1, 1'b0);
        run(40, 1'b1);
        err_mode = 1'b0;
        check_val("t4_sb_drained", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of a burst owned by master 1.
        do_reset();
        start_master(1, 8, 1'b1);
        push_exp(1, 0, 8, 8, 1'b1);
        run(6, 1'b0);
        check_val("t5_pre_rst_gnt", 64'(gnt), 64'(3'b010));
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t5_rst_gnt", 64'(gnt), 64'(0));
        check_val("t5_rst_m_cyc", 64'(m_cyc), 64'(0));
        check_val("t5_rst_s_ack", 64'(s_ack), 64'(0));
        exp_q.delete();
        start_master(1, 1, 1'b0);
        start_master(0, 1, 1'b0);
        push_exp(0, 0, 1, 1, 1'b0);
        push_exp(1, 0, 1, 1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_trace();
        run(40, 1'b1);
        compress_trace();
        check_val("t5_first_gnt", (cv.size() > 1) ? 64'(cv[1]) : 64'hDEAD, 64'(3'b001));
        check_val("t5_sb_drained", 64'(exp_q.size()), 64'(0));

        // Single master, QUANTUM=2: continuous transfers, never preempted.
        do_reset();
        nb = 0;
        b_s_cyc = 1'b1; b_s_stb = 1'b1;
        b_s_adr = 16'h7000; b_s_dat_ms = 16'h7000 ^ 16'h5A5A;
        exp_q.push_back({3'b001, 1'b0, 3'b000, 2'b11, 16'h7000, 16'h7000 ^ 16'h5A5A});
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            b_acked = 1'b0;
            if (c == 0) check_val("b_latency", 64'(b_m_cyc), 64'(0));
            else        check_val("b_cyc_hold", 64'({b_gnt, b_m_cyc}), 64'(2'b11));
            if (b_m_cyc && b_m_stb && b_m_ack) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check_val("b_xfer", 64'({2'b00, b_gnt, b_m_we, b_m_cti, b_m_sel, b_m_adr, b_m_dat_ms}), 64'(e));
                check_val("b_s_ack", 64'(b_s_ack), 64'(1));
                check_val("b_dat_bcast", 64'(b_s_dat_sm), 64'(16'h0BAD));
                b_acked = 1'b1;
                nb++;
            end
            @(posedge clk); #1;
            if (b_acked) begin
                b_s_adr    = b_s_adr + 16'd1;
                b_s_dat_ms = b_s_adr ^ 16'h5A5A;
                exp_q.push_back({3'b001, 1'b0, 3'b000, 2'b11, b_s_adr, b_s_adr ^ 16'h5A5A});
            end
        end
        check_val("b_beats", 64'(nb), 64'(7));
        b_s_cyc = 1'b0; b_s_stb = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
